pattern_window_counter: RTL and testbench

PATTERN_WINDOW_COUNTER -- requirements
Module: pattern_window_counter

---
 rtl/pattern_pkg.sv | 14 +
 rtl/sat_counter.sv | 47 ++++
 rtl/pattern_window_counter.sv | 100 ++++++++++
 tb/tb_pattern_window_counter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared FSM encoding and default widths for the pattern window counter.
// Pure declarations: no latency and no flow control of its own.
package pattern_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 10;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky overflow flag; clear has priority over increment.
// One-cycle update latency; no backpressure, an increment at saturation only sets sat_o.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] value_o,
    output logic         sat_o
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] value_q, value_d;
    logic         sat_q, sat_d;

    always_comb begin
        value_d = value_q;
        sat_d   = sat_q;
        if (clr_i) begin
            value_d = '0;
            sat_d   = 1'b0;
        end else if (inc_i) begin
            if (value_q == MAX) begin
                sat_d = 1'b1;
            end else begin
                value_d = value_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            sat_q   <= sat_d;
        end
    end

    assign value_o = value_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/pattern_window_counter.sv
// Counts hit pulses over a win_len-cycle window and holds the result until ready_i; optional alarm via PATTERN_WINDOW_ALARM_EN.
// Result valid the cycle after the last window cycle; REPORT stalls on ready_i=0, start ignored until handshake.
module pattern_window_counter
    import pattern_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hit,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             ready_i,
`ifdef PATTERN_WINDOW_ALARM_EN
    input  logic [CNT_W-1:0] thresh_i,
    output logic             alarm_o,
`endif
    output logic             busy_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    state_t           state_q;
    logic [WIN_W-1:0] rem_q;
    logic [WIN_W-1:0] win_len_eff;
    logic             start_acc;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_sat;

    // A zero-length request still opens a one-cycle window.
    assign win_len_eff = (win_len == '0) ? WIN_W'(1) : win_len;
    assign start_acc   = start && ((state_q == IDLE) ||
                                   ((state_q == REPORT) && ready_i));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= COUNT;
                        rem_q   <= win_len_eff;
                    end
                end
                COUNT: begin
                    rem_q <= rem_q - WIN_W'(1);
                    if (rem_q == WIN_W'(1)) begin
                        state_q <= REPORT;
                    end
                end
                REPORT: begin
                    if (ready_i) begin
                        if (start) begin
                            state_q <= COUNT;
                            rem_q   <= win_len_eff;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_sat_counter (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (start_acc),
        .inc_i   (hit && (state_q == COUNT)),
        .value_o (cnt_val),
        .sat_o   (cnt_sat)
    );

    assign busy_o  = (state_q == COUNT);
    assign valid_o = (state_q == REPORT);
    assign cnt_o   = valid_o ? cnt_val : '0;
    assign ovf_o   = valid_o && cnt_sat;

`ifdef PATTERN_WINDOW_ALARM_EN
    logic [CNT_W-1:0] thresh_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thresh_q <= '0;
        end else if (start_acc) begin
            thresh_q <= thresh_i;
        end
    end

    assign alarm_o = valid_o && (cnt_val >= thresh_q);
`endif

endmodule

// File: tb/tb_pattern_window_counter.sv
// Directed bench for pattern_window_counter: default-width instance plus a CNT_W=2 instance for saturation.
module tb_pattern_window_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hit = 1'b0, start = 1'b0, ready_i = 1'b0;
    logic [9:0] win_len = '0;
    logic       busy_o, valid_o, ovf_o;
    logic [7:0] cnt_o;

    logic       hit2 = 1'b0, start2 = 1'b0, ready2 = 1'b0;
    logic [9:0] win_len2 = '0;
    logic       busy2, valid2, ovf2;
    logic [1:0] cnt2;

`ifdef PATTERN_WINDOW_ALARM_EN
    logic [7:0] thresh = '0;
    logic       alarm;
    logic [1:0] thresh2 = '0;
    logic       alarm2;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pattern_window_counter #(.CNT_W(8), .WIN_W(10)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .hit      (hit),
        .start    (start),
        .win_len  (win_len),
        .ready_i  (ready_i),
`ifdef PATTERN_WINDOW_ALARM_EN
        .thresh_i (thresh),
        .alarm_o  (alarm),
`endif
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .cnt_o    (cnt_o),
        .ovf_o    (ovf_o)
    );

    pattern_window_counter #(.CNT_W(2), .WIN_W(10)) u_dut2 (
        .clk      (clk),
        .reset    (reset),
        .hit      (hit2),
        .start    (start2),
        .win_len  (win_len2),
        .ready_i  (ready2),
`ifdef PATTERN_WINDOW_ALARM_EN
        .thresh_i (thresh2),
        .alarm_o  (alarm2),
`endif
        .busy_o   (busy2),
        .valid_o  (valid2),
        .cnt_o    (cnt2),
        .ovf_o    (ovf2)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({busy_o, valid_o, ovf_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: busy/valid/ovf=%b expected 000", {busy_o, valid_o, ovf_o});
        end
        checks++;
        if (cnt_o !== 8'd0) begin
            failures++;
            $display("FAIL reset_cnt: cnt_o=%0d expected 0", cnt_o);
        end
        checks++;
        if ({busy2, valid2, ovf2, cnt2} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_dut2: outputs=%b expected 00000", {busy2, valid2, ovf2, cnt2});
        end
        reset = 1'b0;
        step();
        step();
        checks++;
        if ({busy_o, valid_o} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release_idle: busy/valid=%b expected 00", {busy_o, valid_o});
        end
    endtask

    task automatic test_basic();
        win_len = 10'd10;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            hit = (k == 1 || k == 4 || k == 10);
            checks++;
            if ({busy_o, valid_o} !== 2'b10) begin
                failures++;
                $display("FAIL basic_window_c%0d: busy/valid=%b expected 10", k, {busy_o, valid_o});
            end
            step();
        end
        hit = 1'b0;
        checks++;
        if ({busy_o, valid_o} !== 2'b01) begin
            failures++;
            $display("FAIL basic_report_state: busy/valid=%b expected 01", {busy_o, valid_o});
        end
        checks++;
        if (cnt_o !== 8'd3) begin
            failures++;
            $display("FAIL basic_cnt: cnt_o=%0d expected 3", cnt_o);
        end
        checks++;
        if (ovf_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_ovf: ovf_o=%b expected 0", ovf_o);
        end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        checks++;
        if ({busy_o, valid_o, ovf_o, cnt_o} !== 11'd0) begin
            failures++;
            $display("FAIL basic_after_accept: busy=%b valid=%b ovf=%b cnt=%0d expected all 0",
                     busy_o, valid_o, ovf_o, cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        win_len = 10'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        hit = 1'b1;
        step();
        step();
        hit = 1'b0;
        ready_i = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (valid_o !== 1'b1 || cnt_o !== 8'd2 || busy_o !== 1'b0) begin
                failures++;
                $display("FAIL hold_c%0d: valid=%b busy=%b cnt=%0d expected valid=1 busy=0 cnt=2",
                         i, valid_o, busy_o, cnt_o);
            end
            step();
        end
        checks++;
        if (valid_o !== 1'b1 || cnt_o !== 8'd2) begin
            failures++;
            $display("FAIL hold_end: valid=%b cnt=%0d expected valid=1 cnt=2", valid_o, cnt_o);
        end
        ready_i = 1'b1;
        win_len = 10'd4;
        step();
        ready_i = 1'b0;
        start = 1'b0;
        checks++;
        if ({busy_o, valid_o} !== 2'b10 || cnt_o !== 8'd0) begin
            failures++;
            $display("FAIL b2b_restart: busy/valid=%b cnt=%0d expected 10 cnt=0", {busy_o, valid_o}, cnt_o);
        end
        for (int k = 1; k <= 4; k++) begin
            hit = (k == 2);
            step();
        end
        hit = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || cnt_o !== 8'd1 || ovf_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_result: valid=%b cnt=%0d ovf=%b expected valid=1 cnt=1 ovf=0",
                     valid_o, cnt_o, ovf_o);
        end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        win_len = 10'd10;
        start = 1'b1;
        step();
        start = 1'b0;
        hit = 1'b1;
        step();
        step();
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre_busy: busy=%b expected 1", busy_o);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy_o, valid_o, ovf_o, cnt_o} !== 11'd0) begin
            failures++;
            $display("FAIL midrst_async: busy=%b valid=%b ovf=%b cnt=%0d expected all 0",
                     busy_o, valid_o, ovf_o, cnt_o);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if ({busy_o, valid_o} !== 2'b00) begin
                failures++;
                $display("FAIL midrst_no_resume_c%0d: busy/valid=%b expected 00", i, {busy_o, valid_o});
            end
            step();
        end
        hit = 1'b0;
        win_len = 10'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            hit = (k == 2);
            step();
        end
        hit = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || cnt_o !== 8'd1) begin
            failures++;
            $display("FAIL midrst_fresh_window: valid=%b cnt=%0d expected valid=1 cnt=1", valid_o, cnt_o);
        end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
    endtask

    task automatic test_zero_len();
        win_len = 10'd0;
        start = 1'b1;
        step();
        hit = 1'b1;
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL zlen_busy: busy=%b expected 1", busy_o);
        end
        step();
        hit = 1'b0;
        start = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || cnt_o !== 8'd1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL zlen_result: valid=%b busy=%b cnt=%0d expected valid=1 busy=0 cnt=1",
                     valid_o, busy_o, cnt_o);
        end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        checks++;
        if ({busy_o, valid_o} !== 2'b00) begin
            failures++;
            $display("FAIL zlen_idle: busy/valid=%b expected 00", {busy_o, valid_o});
        end
        win_len = 10'd3;
        start = 1'b1;
        step();
        for (int k = 1; k <= 3; k++) begin
            hit = (k != 2);
            checks++;
            if ({busy_o, valid_o} !== 2'b10) begin
                failures++;
                $display("FAIL start_ignored_c%0d: busy/valid=%b expected 10", k, {busy_o, valid_o});
            end
            step();
        end
        hit = 1'b0;
        start = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || cnt_o !== 8'd2) begin
            failures++;
            $display("FAIL start_ignored_result: valid=%b cnt=%0d expected valid=1 cnt=2", valid_o, cnt_o);
        end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
    endtask

    task automatic test_saturate();
        win_len2 = 10'd8;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        hit2 = 1'b1;
        repeat (8) step();
        hit2 = 1'b0;
        checks++;
        if (valid2 !== 1'b1 || cnt2 !== 2'd3 || ovf2 !== 1'b1) begin
            failures++;
            $display("FAIL sat_ovf: valid=%b cnt=%0d ovf=%b expected valid=1 cnt=3 ovf=1", valid2, cnt2, ovf2);
        end
        ready2 = 1'b1;
        step();
        ready2 = 1'b0;
        checks++;
        if ({valid2, ovf2, cnt2} !== 4'b0000) begin
            failures++;
            $display("FAIL sat_idle: valid=%b ovf=%b cnt=%0d expected all 0", valid2, ovf2, cnt2);
        end
        win_len2 = 10'd3;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        hit2 = 1'b1;
        repeat (3) step();
        hit2 = 1'b0;
        checks++;
        if (valid2 !== 1'b1 || cnt2 !== 2'd3 || ovf2 !== 1'b0) begin
            failures++;
            $display("FAIL sat_exact: valid=%b cnt=%0d ovf=%b expected valid=1 cnt=3 ovf=0", valid2, cnt2, ovf2);
        end
        ready2 = 1'b1;
        step();
        ready2 = 1'b0;
    endtask

`ifdef PATTERN_WINDOW_ALARM_EN
    task automatic test_alarm();
        thresh = 8'd2;
        win_len = 10'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            hit = (k != 2);
            step();
        end
        hit = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || alarm !== 1'b1) begin
            failures++;
            $display("FAIL alarm_two_hits: valid=%b alarm=%b expected 1 1", valid_o, alarm);
        end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        checks++;
        if (alarm !== 1'b0) begin
            failures++;
            $display("FAIL alarm_idle: alarm=%b expected 0", alarm);
        end
        thresh = 8'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        thresh = 8'd0;
        for (int k = 1; k <= 3; k++) begin
            hit = (k == 3);
            step();
        end
        hit = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || cnt_o !== 8'd1 || alarm !== 1'b0) begin
            failures++;
            $display("FAIL alarm_one_hit: valid=%b cnt=%0d alarm=%b expected 1 1 0", valid_o, cnt_o, alarm);
        end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_mid();
        test_zero_len();
        test_saturate();
`ifdef PATTERN_WINDOW_ALARM_EN
        test_alarm();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
